fifo_ctrl_multi: RTL and testbench

//  Multi-channel FIFO control logic for the interconnect device: NUM_CH independent FIFOs, one shared clock.
//  Per channel: occupancy counter, wrap-around rd/wr pointers for an external RAM, full/empty flags, thresholded

---
 rtl/fifo_ctrl_multi.sv | 98 +++++++++
 tb/tb_fifo_ctrl_multi.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_multi.sv
// Multi-channel FIFO control: per-channel occupancy, wrap-around RAM pointers,
// registered full/empty/almost flags and sticky overflow/underflow errors.
module fifo_ctrl_multi #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned MEM_SIZE  = 4,
  parameter int unsigned WORD_SIZE = 6,
  parameter int unsigned PTR_L     = 2,
  parameter int unsigned CNT_L     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_L-1:0]        full_threshold,
  input  logic [CNT_L-1:0]        empty_threshold,
  input  logic [NUM_CH-1:0]       fifo_wr,
  input  logic [NUM_CH-1:0]       fifo_rd,
  input  logic [NUM_CH-1:0]       err_clr,
  output logic [NUM_CH-1:0]       wr_en,
  output logic [NUM_CH-1:0]       rd_en,
  output logic [NUM_CH*PTR_L-1:0] wr_ptr,
  output logic [NUM_CH*PTR_L-1:0] rd_ptr,
  output logic [NUM_CH*CNT_L-1:0] count,
  output logic [NUM_CH-1:0]       fifo_full,
  output logic [NUM_CH-1:0]       fifo_empty,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       almost_empty,
  output logic [NUM_CH-1:0]       err_ovf,
  output logic [NUM_CH-1:0]       err_udf,
  output logic                    error
);

  localparam logic [PTR_L-1:0] PTR_LAST = PTR_L'(MEM_SIZE - 1);
  localparam logic [CNT_L-1:0] CNT_FULL = CNT_L'(MEM_SIZE);

  // WORD_SIZE sizes the external RAM only; it is checked here with the pointer widths.
  if (MEM_SIZE < 2 || WORD_SIZE < 1 || PTR_L < $clog2(MEM_SIZE) ||
      CNT_L < $clog2(MEM_SIZE + 1)) begin : g_bad_params
    $error("fifo_ctrl_multi: inconsistent parameters");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_L-1:0] cnt_q, cnt_d;
    logic [PTR_L-1:0] wp_q, rp_q;
    logic             full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
    logic             wr_ok, rd_ok;

    always_comb begin
      rd_ok = fifo_rd[c] & ~empty_q & ~reset;
      wr_ok = fifo_wr[c] & (~full_q | fifo_rd[c]) & ~reset;
      cnt_d = cnt_q;
      if (wr_ok && !rd_ok)
        cnt_d = cnt_q + CNT_L'(1);
      else if (rd_ok && !wr_ok)
        cnt_d = cnt_q - CNT_L'(1);
    end

    // Flags are derived from the next count so they move on the same edge as count.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q   <= '0;
        wp_q    <= '0;
        rp_q    <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
        af_q    <= 1'b0;
        ae_q    <= 1'b1;
        ovf_q   <= 1'b0;
        udf_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (wr_ok)
          wp_q <= (wp_q == PTR_LAST) ? '0 : wp_q + PTR_L'(1);
        if (rd_ok)
          rp_q <= (rp_q == PTR_LAST) ? '0 : rp_q + PTR_L'(1);
        full_q  <= (cnt_d == CNT_FULL);
        empty_q <= (cnt_d == '0);
        af_q    <= (cnt_d >= full_threshold);
        ae_q    <= (cnt_d <= empty_threshold);
        ovf_q   <= (fifo_wr[c] & full_q & ~fifo_rd[c]) | (ovf_q & ~err_clr[c]);
        udf_q   <= (fifo_rd[c] & empty_q) | (udf_q & ~err_clr[c]);
      end
    end

    assign wr_en[c]                    = wr_ok;
    assign rd_en[c]                    = rd_ok;
    assign wr_ptr[c*PTR_L +: PTR_L]    = wp_q;
    assign rd_ptr[c*PTR_L +: PTR_L]    = rp_q;
    assign count[c*CNT_L +: CNT_L]     = cnt_q;
    assign fifo_full[c]                = full_q;
    assign fifo_empty[c]               = empty_q;
    assign almost_full[c]              = af_q;
    assign almost_empty[c]             = ae_q;
    assign err_ovf[c]                  = ovf_q;
    assign err_udf[c]                  = udf_q;
  end

  assign error = |{err_ovf, err_udf};

endmodule

// File: tb/tb_fifo_ctrl_multi.sv
// Bench for fifo_ctrl_multi: integer-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_ctrl_multi;
  localparam int NCH = 2;
  localparam int MEM = 4;
  localparam int PL  = 2;
  localparam int CL  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CL-1:0]   full_threshold = 3'd3;
  logic [CL-1:0]   empty_threshold = 3'd1;
  logic [NCH-1:0]  fifo_wr = '0, fifo_rd = '0, err_clr = '0;
  logic [NCH-1:0]  wr_en, rd_en, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [NCH-1:0]  err_ovf, err_udf;
  logic [NCH*PL-1:0] wr_ptr, rd_ptr;
  logic [NCH*CL-1:0] count;
  logic            error;

  int checks = 0;
  int errors = 0;

  fifo_ctrl_multi #(.NUM_CH(NCH), .MEM_SIZE(MEM), .WORD_SIZE(6), .PTR_L(PL), .CNT_L(CL)) dut (
    .clk(clk), .reset(reset), .full_threshold(full_threshold), .empty_threshold(empty_threshold),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .err_clr(err_clr),
    .wr_en(wr_en), .rd_en(rd_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .err_ovf(err_ovf), .err_udf(err_udf), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers per channel.
  int m_cnt[NCH], m_wp[NCH], m_rp[NCH];
  bit m_af[NCH], m_ae[NCH], m_ovf[NCH], m_udf[NCH];
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        m_cnt[c] = 0; m_wp[c] = 0; m_rp[c] = 0;
        m_af[c] = 0; m_ae[c] = 1; m_ovf[c] = 0; m_udf[c] = 0;
      end else begin
        bit full, empty, rd_a, wr_a, ovf_s, udf_s;
        full  = (m_cnt[c] == MEM);
        empty = (m_cnt[c] == 0);
        rd_a  = fifo_rd[c] && !empty;
        wr_a  = fifo_wr[c] && (!full || fifo_rd[c]);
        ovf_s = fifo_wr[c] && full && !fifo_rd[c];
        udf_s = fifo_rd[c] && empty;
        m_cnt[c] = m_cnt[c] + int'(wr_a) - int'(rd_a);
        m_wp[c]  = (m_wp[c] + int'(wr_a)) % MEM;
        m_rp[c]  = (m_rp[c] + int'(rd_a)) % MEM;
        m_af[c]  = m_cnt[c] >= int'(full_threshold);
        m_ae[c]  = m_cnt[c] <= int'(empty_threshold);
        m_ovf[c] = ovf_s || (m_ovf[c] && !err_clr[c]);
        m_udf[c] = udf_s || (m_udf[c] && !err_clr[c]);
      end
    end
    if (reset) model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      bit any_err;
      #2;
      any_err = 0;
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("m_wr_en%0d", c), 32'(wr_en[c]),
            32'(!reset && fifo_wr[c] && (m_cnt[c] < MEM || fifo_rd[c])));
        chk($sformatf("m_rd_en%0d", c), 32'(rd_en[c]), 32'(!reset && fifo_rd[c] && m_cnt[c] > 0));
        chk($sformatf("m_count%0d", c), 32'(count[c*CL +: CL]), 32'(m_cnt[c]));
        chk($sformatf("m_wr_ptr%0d", c), 32'(wr_ptr[c*PL +: PL]), 32'(m_wp[c]));
        chk($sformatf("m_rd_ptr%0d", c), 32'(rd_ptr[c*PL +: PL]), 32'(m_rp[c]));
        chk($sformatf("m_full%0d", c), 32'(fifo_full[c]), 32'(m_cnt[c] == MEM));
        chk($sformatf("m_empty%0d", c), 32'(fifo_empty[c]), 32'(m_cnt[c] == 0));
        chk($sformatf("m_afull%0d", c), 32'(almost_full[c]), 32'(m_af[c]));
        chk($sformatf("m_aempty%0d", c), 32'(almost_empty[c]), 32'(m_ae[c]));
        chk($sformatf("m_ovf%0d", c), 32'(err_ovf[c]), 32'(m_ovf[c]));
        chk($sformatf("m_udf%0d", c), 32'(err_udf[c]), 32'(m_udf[c]));
        any_err = any_err | m_ovf[c] | m_udf[c];
      end
      chk("m_error", 32'(error), 32'(any_err));
    end
  end

  // Inputs change at the falling edge; combinational outputs are valid 2 time units later.
  task automatic drive(input logic [1:0] wr, input logic [1:0] rd, input logic [1:0] clr);
    @(negedge clk);
    fifo_wr = wr; fifo_rd = rd; err_clr = clr;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] wr, input logic [1:0] rd, input logic [1:0] clr);
    drive(wr, rd, clr);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    drive(2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    tick();
    step(2'b00, 2'b00, 2'b00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd3);
    chk("rst_aempty", 32'(almost_empty), 32'd3);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    step(2'b01, 2'b00, 2'b00);
    chk("w1_count", 32'(count[2:0]), 32'd1);
    chk("w1_aempty", 32'(almost_empty[0]), 32'd1);
    step(2'b01, 2'b00, 2'b00);
    chk("w2_aempty", 32'(almost_empty[0]), 32'd0);
    step(2'b01, 2'b00, 2'b00);
    chk("w3_afull", 32'(almost_full[0]), 32'd1);
    chk("w3_full", 32'(fifo_full[0]), 32'd0);
    step(2'b01, 2'b00, 2'b00);
    chk("w4_count", 32'(count[2:0]), 32'd4);
    chk("w4_full", 32'(fifo_full[0]), 32'd1);
    chk("w4_wrptr", 32'(wr_ptr[1:0]), 32'd0);

    drive(2'b01, 2'b00, 2'b00);
    chk("ovf_wr_en", 32'(wr_en[0]), 32'd0);
    tick();
    chk("ovf_count", 32'(count[2:0]), 32'd4);
    chk("ovf_flag", 32'(err_ovf[0]), 32'd1);
    chk("ovf_error", 32'(error), 32'd1);
    step(2'b00, 2'b00, 2'b01);
    chk("ovf_clr", 32'(err_ovf[0]), 32'd0);

    for (int i = 0; i < 3; i++) step(2'b01, 2'b01, 2'b00);
    chk("wrrd_count", 32'(count[2:0]), 32'd4);
    chk("wrrd_full", 32'(fifo_full[0]), 32'd1);
    chk("wrrd_wptr", 32'(wr_ptr[1:0]), 32'd3);
    chk("wrrd_rptr", 32'(rd_ptr[1:0]), 32'd3);
    chk("wrrd_error", 32'(error), 32'd0);

    drive(2'b10, 2'b10, 2'b00);
    chk("e_wr_en1", 32'(wr_en[1]), 32'd1);
    chk("e_rd_en1", 32'(rd_en[1]), 32'd0);
    tick();
    chk("e_count1", 32'(count[5:3]), 32'd1);
    chk("e_udf1", 32'(err_udf[1]), 32'd1);
    chk("e_count0", 32'(count[2:0]), 32'd4);

    step(2'b00, 2'b01, 2'b00);
    step(2'b00, 2'b01, 2'b00);
    chk("pre_rst_count", 32'(count[2:0]), 32'd2);
    drive(2'b11, 2'b00, 2'b00);
    reset = 1'b1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    tick();
    reset = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ptrs", 32'({wr_ptr, rd_ptr}), 32'd0);
    chk("mid_rst_empty", 32'(fifo_empty), 32'd3);
    chk("mid_rst_error", 32'(error), 32'd0);

    drive(2'b00, 2'b00, 2'b00);
    full_threshold = 3'd0;
    tick();
    chk("thr0_afull", 32'(almost_full), 32'd3);
    full_threshold = 3'd3;

    // Mixed traffic on both channels, including threshold changes; checked by the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] w, r, k;
      w = 2'(i * 3 + (i >> 2));
      r = 2'((i * 5 + 1) >> 1);
      k = (i % 7 == 6) ? 2'b11 : 2'b00;
      if (i == 20) begin full_threshold = 3'd2; empty_threshold = 3'd2; end
      if (i == 30) begin full_threshold = 3'd4; empty_threshold = 3'd0; end
      step(w, r, k);
    end
    step(2'b00, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
